// File: rtl/ann_weight_pkg.sv
// Shared constants and state encoding for the ANN weight BRAM bank controllers.
// One bank holds WEIGHT_DEPTH words of WEIGHT_DW bits, addressed with WEIGHT_AW bits.
package ann_weight_pkg;

    localparam int WEIGHT_DW    = 16;
    localparam int WEIGHT_AW    = 5;
    localparam int WEIGHT_DEPTH = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_LAST = 2'd2
    } state_t;

endpackage

// File: rtl/weight_bram_port_ctrl.sv
// Single-port owner of one weight BRAM bank: loader writes in IDLE, full-bank read
// bursts streamed to the MAC engine in address order, reads taking priority over writes.
module weight_bram_port_ctrl
    import ann_weight_pkg::*;
#(
    parameter int DEPTH = WEIGHT_DEPTH,
    parameter int AW    = WEIGHT_AW,
    parameter int DW    = WEIGHT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    output logic          ld_err,
    input  logic          rd_start,
    output logic          rd_busy,
    output logic          w_valid,
    output logic [DW-1:0] w_data,
    output logic [AW-1:0] w_index,
    output logic          rd_done,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_do
);

    // One extra bit so the range check stays correct even when DEPTH == 2**AW.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t state;
    logic   wr_in_range;

    assign ld_ready    = (state == ST_IDLE) && !rd_start;
    assign wr_in_range = ({1'b0, ld_addr} < DEPTH_EXT);

    // bram_addr doubles as the burst address counter; it always names the op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ld_err    <= 1'b0;
            rd_busy   <= 1'b0;
            w_valid   <= 1'b0;
            w_data    <= '0;
            w_index   <= '0;
            rd_done   <= 1'b0;
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_di   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads the
            // pre-edge value of bram_addr/state regardless of statement order.
            case (state)
                ST_IDLE: begin
                    w_valid <= 1'b0;
                    rd_done <= 1'b0;
                    if (rd_start) begin
                        state     <= ST_READ;
                        rd_busy   <= 1'b1;
                        bram_en   <= 1'b1;
                        bram_we   <= 1'b0;
                        bram_addr <= '0;
                    end else if (ld_valid) begin
                        // Out-of-range writes are accepted but never reach the BRAM.
                        bram_en <= wr_in_range;
                        bram_we <= wr_in_range;
                        if (wr_in_range) begin
                            bram_addr <= ld_addr;
                            bram_di   <= ld_data;
                        end else begin
                            ld_err <= 1'b1;
                        end
                    end else begin
                        bram_en <= 1'b0;
                        bram_we <= 1'b0;
                    end
                end

                ST_READ: begin
                    w_valid <= 1'b1;
                    w_data  <= bram_do;
                    w_index <= bram_addr;
                    bram_we <= 1'b0;
                    if (bram_addr == LAST_ADDR) begin
                        state   <= ST_LAST;
                        bram_en <= 1'b0;
                        rd_done <= 1'b1;
                    end else begin
                        bram_addr <= bram_addr + AW'(1);
                    end
                end

                ST_LAST: begin
                    state     <= ST_IDLE;
                    rd_busy   <= 1'b0;
                    w_valid   <= 1'b0;
                    rd_done   <= 1'b0;
                    w_index   <= '0;
                    bram_addr <= '0;
                end

                default: begin
                    state   <= ST_IDLE;
                    rd_busy <= 1'b0;
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule
